// File: rtl/img_proc_ctrl_if.sv
// BRAM-side bus of the image controller: receiver/transmitter requests and
// the two physical BRAM ports. "master" is the controller side.
interface img_proc_ctrl_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
);
    logic              rx_ena;
    logic              rx_wea;
    logic [ADDR_W-1:0] rx_addr;
    logic [DATA_W-1:0] rx_din;

    logic              tx_ena;
    logic [ADDR_W-1:0] tx_addr;
    logic [DATA_W-1:0] tx_dout;

    logic              orig_ena;
    logic              orig_wea;
    logic [ADDR_W-1:0] orig_addr;
    logic [DATA_W-1:0] orig_din;
    logic [DATA_W-1:0] orig_dout;

    logic              proc_ena;
    logic              proc_wea;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_din;
    logic [DATA_W-1:0] proc_dout;

    modport master (
        input  rx_ena, rx_wea, rx_addr, rx_din,
        input  tx_ena, tx_addr,
        output tx_dout,
        output orig_ena, orig_wea, orig_addr, orig_din,
        input  orig_dout,
        output proc_ena, proc_wea, proc_addr, proc_din,
        input  proc_dout
    );

    modport slave (
        output rx_ena, rx_wea, rx_addr, rx_din,
        output tx_ena, tx_addr,
        input  tx_dout,
        input  orig_ena, orig_wea, orig_addr, orig_din,
        output orig_dout,
        input  proc_ena, proc_wea, proc_addr, proc_din,
        output proc_dout
    );
endinterface

// File: rtl/img_proc_ctrl.sv
// Phase sequencer (IDLE/RX/PROC/READY/TX) and BRAM port arbiter with an
// internal streaming per-pixel engine from the original to the processed image.
module img_proc_ctrl #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NPIX   = 16384,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        recieve,
    input  logic        transmit,
    input  logic        abort,
    input  logic [1:0]  op_sel,
    input  logic [7:0]  op_arg,
    input  logic        rx_complete,
    input  logic        tx_complete,
    img_proc_ctrl_if.master bus,
    output logic [2:0]  state,
    output logic        proc_done
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_PROC  = 3'd2,
        S_READY = 3'd3,
        S_TX    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    state_t            state_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] arg_q;

    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_done;
    logic              rd_active;
    logic              vld_pipe  [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_din;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] pix_f;

    assign state     = state_q;
    assign rd_active = (state_q == S_PROC) && !rd_done;

    always_comb begin
        sum   = {1'b0, bus.orig_dout} + {1'b0, arg_q};
        pix_f = bus.orig_dout;
        case (op_q)
            2'd0: pix_f = bus.orig_dout;
            2'd1: pix_f = ~bus.orig_dout;
            2'd2: pix_f = (bus.orig_dout >= arg_q) ? '1 : '0;
            2'd3: pix_f = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            default: pix_f = bus.orig_dout;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            proc_done <= 1'b0;
            op_q      <= '0;
            arg_q     <= '0;
            rd_cnt    <= '0;
            rd_done   <= 1'b0;
            wr_vld    <= 1'b0;
            wr_addr   <= '0;
            wr_din    <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_pipe[i]  <= 1'b0;
                addr_pipe[i] <= '0;
            end
        end else begin
            proc_done <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (recieve)       state_q <= S_RX;
                        else if (transmit) state_q <= S_TX;
                    end
                    S_RX: begin
                        if (rx_complete) begin
                            state_q <= S_PROC;
                            op_q    <= op_sel;
                            arg_q   <= DATA_W'(op_arg);
                        end
                    end
                    S_PROC: begin
                        if (wr_vld && (wr_addr == LAST)) begin
                            state_q   <= S_READY;
                            proc_done <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (recieve)       state_q <= S_RX;
                        else if (transmit) state_q <= S_TX;
                    end
                    S_TX: begin
                        if (tx_complete) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            // Engine is held cleared outside PROC so every PROC entry starts at address 0.
            if (state_q != S_PROC) begin
                rd_cnt  <= '0;
                rd_done <= 1'b0;
                wr_vld  <= 1'b0;
                for (int unsigned i = 0; i < RD_LAT; i++) begin
                    vld_pipe[i] <= 1'b0;
                end
            end else begin
                if (rd_active) begin
                    if (rd_cnt == LAST) rd_done <= 1'b1;
                    else                rd_cnt  <= rd_cnt + 1'b1;
                end
                vld_pipe[0]  <= rd_active;
                addr_pipe[0] <= rd_cnt;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    vld_pipe[i]  <= vld_pipe[i-1];
                    addr_pipe[i] <= addr_pipe[i-1];
                end
                wr_vld  <= vld_pipe[RD_LAT-1];
                wr_addr <= addr_pipe[RD_LAT-1];
                wr_din  <= pix_f;
            end
        end
    end

    always_comb begin
        bus.orig_ena  = 1'b0;
        bus.orig_wea  = 1'b0;
        bus.orig_addr = '0;
        bus.orig_din  = '0;
        bus.proc_ena  = 1'b0;
        bus.proc_wea  = 1'b0;
        bus.proc_addr = '0;
        bus.proc_din  = '0;
        case (state_q)
            S_RX: begin
                bus.orig_ena  = bus.rx_ena;
                bus.orig_wea  = bus.rx_wea;
                bus.orig_addr = bus.rx_addr;
                bus.orig_din  = bus.rx_din;
            end
            S_PROC: begin
                bus.orig_ena  = rd_active;
                bus.orig_addr = rd_cnt;
                bus.proc_ena  = wr_vld;
                bus.proc_wea  = wr_vld;
                bus.proc_addr = wr_addr;
                bus.proc_din  = wr_din;
            end
            S_TX: begin
                bus.proc_ena  = bus.tx_ena;
                bus.proc_addr = bus.tx_addr;
            end
            default: ;
        endcase
    end

    assign bus.tx_dout = bus.proc_dout;
endmodule

// File: tb/tb_img_proc_ctrl.sv
// Scoreboard bench: a 16-pixel RD_LAT=1 instance for phase/arbitration/op
// checks and a full-size RD_LAT=2 instance for the long PROC run.
module tb_img_proc_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] f_model(input logic [1:0] op, input logic [7:0] arg,
                                           input logic [7:0] p);
        int s;
        s = int'(p) + int'(arg);
        case (op)
            2'd0: return p;
            2'd1: return 8'(255 - int'(p));
            2'd2: return (p >= arg) ? 8'd255 : 8'd0;
            default: return (s > 255) ? 8'd255 : 8'(s);
        endcase
    endfunction

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    // ---------------- small instance ----------------
    logic       recv0, trans0, abort0, rxc0, txc0, done0;
    logic [1:0] op_sel0;
    logic [7:0] op_arg0;
    logic [2:0] state0;
    img_proc_ctrl_if #(.ADDR_W(4), .DATA_W(8)) b0 ();

    img_proc_ctrl #(.ADDR_W(4), .DATA_W(8), .NPIX(16), .RD_LAT(1)) u_small (
        .clk(clk), .reset(rst_n), .recieve(recv0), .transmit(trans0), .abort(abort0),
        .op_sel(op_sel0), .op_arg(op_arg0), .rx_complete(rxc0), .tx_complete(txc0),
        .bus(b0), .state(state0), .proc_done(done0)
    );

    logic [7:0] orig0 [16];
    logic [7:0] proc0 [16];
    logic [7:0] o0_q, p0_q;
    always @(posedge clk) begin
        if (b0.orig_ena) begin
            if (b0.orig_wea) orig0[b0.orig_addr] <= b0.orig_din;
            o0_q <= orig0[b0.orig_addr];
        end
        if (b0.proc_ena) begin
            if (b0.proc_wea) proc0[b0.proc_addr] <= b0.proc_din;
            p0_q <= proc0[b0.proc_addr];
        end
    end
    assign b0.orig_dout = o0_q;
    assign b0.proc_dout = p0_q;

    wr_t q0[$];
    int  wr0_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && b0.proc_ena && b0.proc_wea) begin
            wr_t e;
            wr0_cnt++;
            if (q0.size() == 0) begin
                check("wr0_unexpected", 32'(b0.proc_addr), 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                check("wr0_addr", 32'(b0.proc_addr), 32'(e.addr[3:0]));
                check("wr0_data", 32'(b0.proc_din), 32'(e.data));
            end
        end
    end

    // ---------------- full-size instance ----------------
    logic       recv1, trans1, abort1, rxc1, txc1, done1;
    logic [1:0] op_sel1;
    logic [7:0] op_arg1;
    logic [2:0] state1;
    img_proc_ctrl_if #(.ADDR_W(14), .DATA_W(8)) b1 ();

    img_proc_ctrl #(.ADDR_W(14), .DATA_W(8), .NPIX(16384), .RD_LAT(2)) u_big (
        .clk(clk), .reset(rst_n), .recieve(recv1), .transmit(trans1), .abort(abort1),
        .op_sel(op_sel1), .op_arg(op_arg1), .rx_complete(rxc1), .tx_complete(txc1),
        .bus(b1), .state(state1), .proc_done(done1)
    );

    logic [7:0] orig1 [16384];
    logic [7:0] proc1 [16384];
    logic [7:0] o1_s1, o1_q, p1_q;
    always @(posedge clk) begin
        if (b1.orig_ena) o1_s1 <= orig1[b1.orig_addr];
        o1_q <= o1_s1;
        if (b1.proc_ena) begin
            if (b1.proc_wea) proc1[b1.proc_addr] <= b1.proc_din;
            p1_q <= proc1[b1.proc_addr];
        end
    end
    assign b1.orig_dout = o1_q;
    assign b1.proc_dout = p1_q;

    wr_t q1[$];
    int  wr1_cnt   = 0;
    int  last_addr1 = -1;
    always @(negedge clk) begin
        if (rst_n && b1.proc_ena && b1.proc_wea) begin
            wr_t e;
            wr1_cnt++;
            last_addr1 = int'(b1.proc_addr);
            if (q1.size() == 0) begin
                check("wr1_unexpected", 32'(b1.proc_addr), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check("wr1_addr", 32'(b1.proc_addr), 32'(e.addr));
                check("wr1_data", 32'(b1.proc_din), 32'(e.data));
            end
        end
    end

    // ---------------- small-instance helpers ----------------
    logic [7:0] pix0 [16];
    logic [7:0] exp0 [16];

    task automatic rx_load0();
        for (int k = 0; k < 16; k++) begin
            b0.rx_ena  = 1'b1;
            b0.rx_wea  = 1'b1;
            b0.rx_addr = 4'(k);
            b0.rx_din  = pix0[k];
            @(posedge clk); #1;
        end
        b0.rx_ena = 1'b0;
        b0.rx_wea = 1'b0;
    endtask

    task automatic run_proc0(input logic [1:0] op, input logic [7:0] arg, input int abort_at,
                             output int cycles, output int dones);
        for (int k = 0; k < 16; k++) begin
            exp0[k] = f_model(op, arg, pix0[k]);
            q0.push_back('{addr: 14'(k), data: exp0[k]});
        end
        op_sel0 = op;
        op_arg0 = arg;
        rxc0    = 1'b1;
        @(posedge clk); #1;
        rxc0    = 1'b0;
        // Latched values must win over these later changes and over foreign requests.
        op_sel0    = ~op;
        op_arg0    = 8'($urandom);
        b0.rx_ena  = 1'b1;
        b0.rx_wea  = 1'b1;
        b0.rx_addr = 4'd2;
        b0.rx_din  = 8'h55;
        b0.tx_ena  = 1'b1;
        b0.tx_addr = 4'd9;
        cycles = 0;
        dones  = 0;
        while (state0 == 3'd2 && cycles < 100) begin
            check("arb_orig_wea", 32'(b0.orig_wea), 32'd0);
            if (cycles == abort_at) abort0 = 1'b1;
            cycles++;
            @(posedge clk); #1;
            abort0 = 1'b0;
            if (done0) dones++;
        end
        b0.rx_ena = 1'b0;
        b0.rx_wea = 1'b0;
        b0.tx_ena = 1'b0;
    endtask

    initial begin
        int cycles, dones, base;
        logic [7:0] old0 [16];

        rst_n = 1'b0;
        {recv0, trans0, abort0, rxc0, txc0} = '0;
        {recv1, trans1, abort1, rxc1, txc1} = '0;
        op_sel0 = '0; op_arg0 = '0; op_sel1 = '0; op_arg1 = '0;
        b0.rx_ena = 1'b0; b0.rx_wea = 1'b0; b0.rx_addr = '0; b0.rx_din = '0;
        b0.tx_ena = 1'b0; b0.tx_addr = '0;
        b1.rx_ena = 1'b0; b1.rx_wea = 1'b0; b1.rx_addr = '0; b1.rx_din = '0;
        b1.tx_ena = 1'b0; b1.tx_addr = '0;
        for (int k = 0; k < 16384; k++) orig1[k] = 8'(k) ^ 8'(k >> 6);

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state0), 32'd0);
        check("rst_orig_ena", 32'(b0.orig_ena), 32'd0);
        check("rst_proc_ena", 32'(b0.proc_ena), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_state", 32'(state0), 32'd0);
        check("idle_proc_wea", 32'(b0.proc_wea), 32'd0);
        check("idle_state_big", 32'(state1), 32'd0);

        txc0 = 1'b1;
        @(posedge clk); #1;
        txc0 = 1'b0;
        check("txc_in_idle", 32'(state0), 32'd0);

        recv0 = 1'b1;
        @(posedge clk); #1;
        recv0 = 1'b0;
        check("recv_to_rx", 32'(state0), 32'd1);
        b0.rx_ena = 1'b1; b0.rx_wea = 1'b1; b0.rx_addr = 4'd5; b0.rx_din = 8'hA7;
        #1;
        check("rx_pass_addr", 32'(b0.orig_addr), 32'd5);
        check("rx_pass_din", 32'(b0.orig_din), 32'hA7);
        check("rx_pass_wea", 32'(b0.orig_wea), 32'd1);
        check("rx_pass_ena", 32'(b0.orig_ena), 32'd1);
        check("rx_proc_idle", 32'(b0.proc_ena), 32'd0);
        @(posedge clk); #1;

        // Invert
        for (int k = 0; k < 16; k++) pix0[k] = 8'(k * 16);
        rx_load0();
        run_proc0(2'b01, 8'd0, -1, cycles, dones);
        check("inv_cycles", 32'(cycles), 32'd18);
        check("inv_dones", 32'(dones), 32'd1);
        check("inv_state", 32'(state0), 32'd3);
        check("inv_q_empty", 32'(q0.size()), 32'd0);
        check("inv_proc0", 32'(proc0[0]), 32'd255);
        check("inv_proc15", 32'(proc0[15]), 32'd15);
        check("inv_orig2_kept", 32'(orig0[2]), 32'd32);
        check("inv_orig7_kept", 32'(orig0[7]), 32'd112);
        @(posedge clk); #1;
        check("inv_done_pulse", 32'(done0), 32'd0);

        // Priority in READY
        recv0 = 1'b1; trans0 = 1'b1;
        @(posedge clk); #1;
        recv0 = 1'b0; trans0 = 1'b0;
        check("ready_prio", 32'(state0), 32'd1);

        // Threshold
        for (int k = 0; k < 16; k++) pix0[k] = 8'($urandom);
        pix0[0] = 8'd99; pix0[1] = 8'd100; pix0[2] = 8'd255;
        rx_load0();
        run_proc0(2'b10, 8'd100, -1, cycles, dones);
        check("thr_cycles", 32'(cycles), 32'd18);
        check("thr_state", 32'(state0), 32'd3);
        check("thr_q_empty", 32'(q0.size()), 32'd0);
        check("thr_p0", 32'(proc0[0]), 32'd0);
        check("thr_p1", 32'(proc0[1]), 32'd255);
        check("thr_p2", 32'(proc0[2]), 32'd255);

        // Saturating add
        recv0 = 1'b1;
        @(posedge clk); #1;
        recv0 = 1'b0;
        for (int k = 0; k < 16; k++) pix0[k] = 8'($urandom);
        pix0[0] = 8'd0; pix0[1] = 8'd55; pix0[2] = 8'd56; pix0[3] = 8'd255;
        rx_load0();
        run_proc0(2'b11, 8'd200, -1, cycles, dones);
        check("sat_dones", 32'(dones), 32'd1);
        check("sat_q_empty", 32'(q0.size()), 32'd0);
        check("sat_p0", 32'(proc0[0]), 32'd200);
        check("sat_p1", 32'(proc0[1]), 32'd255);
        check("sat_p2", 32'(proc0[2]), 32'd255);
        check("sat_p3", 32'(proc0[3]), 32'd255);

        // Transmit
        trans0 = 1'b1;
        @(posedge clk); #1;
        trans0 = 1'b0;
        check("ready_to_tx", 32'(state0), 32'd4);
        b0.tx_ena = 1'b1; b0.tx_addr = 4'd3;
        #1;
        check("tx_proc_addr", 32'(b0.proc_addr), 32'd3);
        check("tx_proc_wea", 32'(b0.proc_wea), 32'd0);
        check("tx_proc_ena", 32'(b0.proc_ena), 32'd1);
        check("tx_orig_ena", 32'(b0.orig_ena), 32'd0);
        rxc0 = 1'b1;
        @(posedge clk); #1;
        rxc0 = 1'b0;
        b0.tx_ena = 1'b0;
        check("tx_dout", 32'(b0.tx_dout), 32'(exp0[3]));
        check("rxc_in_tx", 32'(state0), 32'd4);
        txc0 = 1'b1;
        @(posedge clk); #1;
        txc0 = 1'b0;
        check("tx_to_idle", 32'(state0), 32'd0);

        // Abort at PROC cycle 7
        recv0 = 1'b1;
        @(posedge clk); #1;
        recv0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            old0[k] = exp0[k];
            pix0[k] = ~exp0[k];
        end
        rx_load0();
        base = wr0_cnt;
        run_proc0(2'b00, 8'd0, 7, cycles, dones);
        check("abort_state", 32'(state0), 32'd0);
        check("abort_cycles", 32'(cycles), 32'd8);
        check("abort_dones", 32'(dones), 32'd0);
        check("abort_writes", 32'(wr0_cnt - base), 32'd6);
        check("abort_q_left", 32'(q0.size()), 32'd10);
        q0.delete();
        check("abort_p5_new", 32'(proc0[5]), 32'(pix0[5]));
        for (int k = 6; k < 16; k++) check("abort_kept", 32'(proc0[k]), 32'(old0[k]));
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_late_wr", 32'(wr0_cnt - base), 32'd6);

        // Full-size image, RD_LAT=2
        recv1 = 1'b1;
        @(posedge clk); #1;
        recv1 = 1'b0;
        check("big_rx", 32'(state1), 32'd1);
        for (int k = 0; k < 16384; k++)
            q1.push_back('{addr: 14'(k), data: f_model(2'b01, 8'd0, orig1[k])});
        op_sel1 = 2'b01;
        rxc1 = 1'b1;
        @(posedge clk); #1;
        rxc1 = 1'b0;
        cycles = 0;
        dones  = 0;
        while (state1 == 3'd2 && cycles < 20000) begin
            cycles++;
            @(posedge clk); #1;
            if (done1) dones++;
        end
        check("big_cycles", 32'(cycles), 32'd16387);
        check("big_state", 32'(state1), 32'd3);
        check("big_dones", 32'(dones), 32'd1);
        check("big_writes", 32'(wr1_cnt), 32'd16384);
        check("big_last_addr", 32'(last_addr1), 32'd16383);
        check("big_q_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/img_proc_ctrl.md
Name: img_proc_ctrl

Overview:
- Phase sequencer and port arbiter for the two single-port image BRAMs: original and processed.
- Grants the original BRAM port to the UART image receiver during RX.
- Runs an internal per-pixel engine, original → processed, during PROC.
- Grants the processed BRAM port to the UART image transmitter during TX.
- Only one owner per BRAM port at any time.

Parameters:
ADDR_W, 14, BRAM address width
DATA_W, 8, pixel width (ops below defined for 8)
NPIX, 16384, pixels per image (128x128); addresses 0..NPIX-1
RD_LAT, 1, BRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
recieve  in  1  level request: start receive phase
transmit  in  1  level request: start transmit phase
abort  in  1  synchronous: return to IDLE from any state
op_sel  in  2  pixel op, latched on PROC entry
op_arg  in  8  op operand, latched on PROC entry
rx_complete  in  1  pulse from receiver: last pixel written
tx_complete  in  1  pulse from transmitter: last byte sent
rx_ena / rx_wea / rx_addr / rx_din  in  1/1/ADDR_W/DATA_W  receiver BRAM request
tx_ena / tx_addr  in  1/ADDR_W  transmitter read request
tx_dout  out  DATA_W  processed BRAM read data to transmitter
orig_ena / orig_wea / orig_addr / orig_din  out  1/1/ADDR_W/DATA_W  original BRAM port
orig_dout  in  DATA_W  original BRAM read data
proc_ena / proc_wea / proc_addr / proc_din  out  1/1/ADDR_W/DATA_W  processed BRAM port
proc_dout  in  DATA_W  processed BRAM read data
state  out  3  IDLE=0, RX=1, PROC=2, READY=3, TX=4
proc_done  out  1  one-cycle pulse when PROC finishes

Behaviour:
- Reset (reset=0, async): state=IDLE, counters=0, latched op/arg=0, all *_ena/*_wea=0, addresses/din=0, proc_done=0.
- Transitions, registered:
  - IDLE: recieve → RX. Else transmit → TX (re-send the existing processed image).
  - RX: rx_complete → PROC.
  - PROC: after the write of address NPIX-1 → READY, with proc_done=1 for that one cycle.
  - READY: recieve → RX (takes priority). Else transmit → TX.
  - TX: tx_complete → IDLE.
  - abort=1 → IDLE next cycle from any state. Abort takes priority over all other transitions. Any in-flight PROC writes are dropped.
  - Requests in other states are ignored.
- Port muxing (combinational from state):
  - RX: orig_* = rx_*.
  - TX: proc_ena=tx_ena, proc_addr=tx_addr, proc_wea=0, proc_din=0. tx_dout=proc_dout in all states.
  - PROC: both ports driven by the engine.
  - All other cases: ena=wea=0, and non-owner requests are ignored.
- Engine:
  - The read counter starts at 0 on the first PROC cycle and issues orig_ena=1, orig_wea=0, orig_addr=rd_cnt, one per cycle, through NPIX-1. Reads then stop.
  - orig_dout for read k is valid RD_LAT cycles later.
  - The result is registered: proc_ena=proc_wea=1, proc_addr=k, proc_din=f(p), asserted RD_LAT+1 cycles after read k is issued.
  - PROC lasts exactly NPIX+RD_LAT+1 cycles.
  - Write address is a delayed copy of the read address, pipelined with a valid bit. No stalls.
- f(p), 8-bit unsigned:
  - 00: p
  - 01: 255-p
  - 10: (p >= op_arg) ? 255 : 0
  - 11: min(p+op_arg, 255), computed at 9 bits then clamped
- Counter wrap: rd_cnt never exceeds NPIX-1. When NPIX = 2^ADDR_W, the terminal condition uses a separate done flag, not the counter's wrap.
- op_sel/op_arg changes during PROC have no effect.
- rx_complete outside RX and tx_complete outside TX are ignored.
- Reset asserted mid-PROC: all enables drop immediately (async), the pipeline is flushed, and the state goes to IDLE.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release → state=0, all enables 0. A recieve pulse gives state=1 the next cycle; rx_addr=5, rx_din=8'hA7, rx_wea=1 appear unchanged on orig_*.
- Invert: NPIX=16, RD_LAT=1, orig holds k*16. op_sel=01 on rx_complete → proc[k]=255-16k (proc[0]=255, proc[15]=15). PROC lasts 18 cycles, with proc_done high exactly once, then state=3.
- Threshold and saturating add:
  - op_sel=10, op_arg=100, pixels {99,100,255} → {0,255,255}.
  - op_sel=11, op_arg=200, pixels {0,55,56,255} → {200,255,255,255}.
- Arbitration: in PROC, drive rx_ena=1, rx_wea=1, tx_ena=1 → orig_* and proc_* follow only the engine, and orig data is unaltered. In TX, tx_addr=3 → proc_addr=3, proc_wea=0, tx_dout=proc[3].
- Priority and abort:
  - recieve and transmit high together in READY → RX.
  - abort at PROC cycle 7 → IDLE next cycle; proc addresses ≥6 are not written.
  - tx_complete in IDLE → no change.
- RD_LAT=2 with NPIX=16384: last write is to address 16383, PROC lasts 16387 cycles, no writes beyond 16383.
